// File: rtl/avg_window_feed_if.sv
// avg_window_feed_if: sample/feedback bundle for the windowed averager.
// The master side supplies samples, window length, overrun clear and the
// divider's quotient. The slave side (the averager) returns the divider
// operands and the average with its status flags.
//
// Handshake: there is no back-pressure. A sample is consumed on every
// rising clk edge where sample_valid is high. avg_valid is a one-cycle
// pulse qualifying avg_out. dividend/divisor are level outputs that only
// change when a completed window is launched toward the divider.
interface avg_window_feed_if;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic [15:0]        win_len;
  logic               ovr_clr;
  logic [31:0]        dividend;
  logic [15:0]        divisor;
  logic [31:0]        quotient;
  logic signed [15:0] avg_out;
  logic               avg_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output sample_in, sample_valid, win_len, ovr_clr, quotient,
    input  dividend, divisor, avg_out, avg_valid, busy, overrun
  );

  modport slave (
    input  sample_in, sample_valid, win_len, ovr_clr, quotient,
    output dividend, divisor, avg_out, avg_valid, busy, overrun
  );
endinterface

// File: rtl/avg_window_feed.sv
// avg_window_feed: windowed sample averager feeding a shift-subtract divider.
// Signed 16-bit samples are summed over a programmable window. A finished
// window is launched to the divider as a stable dividend/divisor pair; after
// SETTLE cycles the divider's quotient is captured and emitted as a one-cycle
// valid average. Accumulation keeps running while the divider is busy, so a
// window that completes during the wait is dropped and flagged as overrun.
//
// Optional feature macro: AVG_ROUND_EN
//   defined   - launched dividend is biased by len>>1 away from zero so the
//               truncating divider rounds to nearest, ties away from zero.
//   undefined - launched dividend is the raw sum (truncation toward zero).
//
// SETTLE must be at least 36: the divider needs 35 edges after an operand
// change before its quotient is valid.
module avg_window_feed #(
  parameter int unsigned SETTLE = 40
) (
  input  logic            clk,
  input  logic            rst,
  avg_window_feed_if.slave bus,
  output logic            state_dbg
);

  localparam int unsigned WCW      = $clog2(SETTLE + 1);
  localparam logic [WCW-1:0] SETTLE_W = WCW'(SETTLE);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_n;

  // Accumulation side
  logic [31:0] acc;
  logic [15:0] cnt;
  logic [15:0] len;

  // Divider wait counter; counts edges since launch
  logic [WCW-1:0] wc;

  // Combinational helpers
  logic [15:0] wl_sat;
  logic [15:0] eff_len;
  logic [31:0] sum_full;
  logic [31:0] half_len;
  logic [31:0] launch_sum;
  logic        last;
  logic        capture;
  logic        launch;
  logic        drop;

  // Upper quotient bits are never needed: the average always fits 16 bits.
  logic unused_quotient_hi;
  assign unused_quotient_hi = ^bus.quotient[31:16];

  assign state_dbg = state;
  assign bus.busy  = (state == S_WAIT);

  // Window bookkeeping: effective length, running sum and launch decisions.
  // While cnt is 0 a new window is about to start, so the length comes
  // straight from win_len; afterwards the latched copy is used.
  always_comb begin
    wl_sat   = (bus.win_len == 16'd0) ? 16'd1 : bus.win_len;
    eff_len  = (cnt == 16'd0) ? wl_sat : len;
    sum_full = acc + {{16{bus.sample_in[15]}}, bus.sample_in};
    half_len = {17'd0, eff_len[15:1]};
    last     = bus.sample_valid && (cnt == (eff_len - 16'd1));
    capture  = (state == S_WAIT) && (wc == SETTLE_W);
    launch   = last && ((state == S_IDLE) || capture);
    drop     = last && !launch;
  end

  // Dividend presented at launch; optional bias turns truncation into rounding.
  always_comb begin
`ifdef AVG_ROUND_EN
    launch_sum = sum_full[31] ? (sum_full - half_len) : (sum_full + half_len);
`else
    launch_sum = sum_full;
`endif
  end

  // Wait-state FSM next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (launch) state_n = S_WAIT;
      S_WAIT: if (capture && !launch) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Wait-state FSM register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Accumulator, sample count and latched window length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 32'd0;
      cnt <= 16'd0;
      len <= 16'd1;
    end else if (bus.sample_valid) begin
      if (last) begin
        acc <= 32'd0;
        cnt <= 16'd0;
        len <= wl_sat;
      end else begin
        acc <= sum_full;
        cnt <= cnt + 16'd1;
        len <= eff_len;
      end
    end else if (cnt == 16'd0) begin
      len <= wl_sat;
    end
  end

  // Divider operands: only touched when a window is launched, so they stay
  // stable for the full divider latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dividend <= 32'd0;
      bus.divisor  <= 16'd1;
    end else if (launch) begin
      bus.dividend <= launch_sum;
      bus.divisor  <= eff_len;
    end
  end

  // Wait counter: restarts at 1 on launch, free-runs while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wc <= '0;
    else if (launch)          wc <= WCW'(1);
    else if (state == S_WAIT) wc <= wc + WCW'(1);
  end

  // Quotient capture and the one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.avg_out   <= 16'sd0;
      bus.avg_valid <= 1'b0;
    end else begin
      bus.avg_valid <= capture;
      if (capture) bus.avg_out <= bus.quotient[15:0];
    end
  end

  // Sticky overrun flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              bus.overrun <= 1'b0;
    else if (drop)        bus.overrun <= 1'b1;
    else if (bus.ovr_clr) bus.overrun <= 1'b0;
  end

endmodule

// File: doc/avg_window_feed.md
# avg_window_feed

Windowed sample averager wrapped around the shift-subtract divider. It accumulates signed 16-bit samples over a programmable window and presents the sum and count to the divider as stable `dividend`/`divisor`. After a fixed settle time it captures the divider's `quotient` and emits a one-cycle-valid average. It sits directly upstream of the divider (feeding it) and directly downstream of it (consuming `quotient`).

## Interface
- `SETTLE`, default 40: cycles from operand update to quotient capture. Must be ≥36, because the divider needs 35 edges after an operand change.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `sample_in` in 16: signed sample.
- `sample_valid` in 1: `sample_in` is accepted on any edge where this is high.
- `win_len` in 16: window length in samples, read at window start. The value 0 is treated as 1.
- `ovr_clr` in 1: clears `overrun`.
- `dividend` out 32: window sum (two's complement) to divider.
- `divisor` out 16: window length to divider.
- `quotient` in 32: divider result.
- `avg_out` out 16: signed average, equal to `quotient[15:0]`.
- `avg_valid` out 1: one-cycle pulse when `avg_out` updates.
- `busy` out 1: high while waiting on the divider.
- `overrun` out 1: sticky flag; a completed window was dropped.

## Operation
- Reset values:
  - `dividend`=0, `divisor`=1, `avg_out`=0.
  - `avg_valid`=0, `busy`=0, `overrun`=0.
  - Internal `acc`=0, sample count `cnt`=0.
  - The latched window length `len` is loaded from `win_len` (0→1) on the first edge after reset release.
- Accumulation runs independently of the divider wait, so the block is double-buffered.
  - Each accepted sample is sign-extended to 32 bits and added to `acc`; `cnt` increments.
  - `len` is reloaded from `win_len` whenever `cnt` returns to 0.
- Window complete: the edge where a sample is accepted with `cnt`=`len`-1.
  - `acc` and `cnt` clear; `len` reloads.
  - If not busy, or the capture happens on this same edge: `dividend` takes the full window sum (with the adjustment below), `divisor` takes `len`, `busy` goes to 1, and the wait counter `wc` is set to 1.
  - Otherwise: the window is discarded and `overrun` is set to 1.
- Waiting (`busy`=1):
  - `wc` increments each edge.
  - On the edge where `wc`=`SETTLE`: `avg_out` takes `quotient[15:0]`, `avg_valid` is 1 for exactly one cycle, and `busy` goes to 0.
  - If a new window completes on that same edge, the new window is launched and `busy` stays 1.
- `dividend` and `divisor` change only at window launch. They are held constant for at least `SETTLE` cycles so the divider does not restart mid-computation.
- Arithmetic:
  - Range is ±32768·65535, which fits in 32 bits signed.
  - Division truncates toward zero.
  - The result always fits in 16 bits signed, so `quotient[31:16]` is ignored.
- `ovr_clr` clears `overrun`. If `ovr_clr` and a new overrun occur on the same edge, the set wins.
- Reset mid-operation: the partial window, any pending wait, and `overrun` are all lost. No `avg_valid` is produced for the aborted window.

## Timing
- Launch edge T (the last sample of the window is accepted): `dividend`/`divisor` are valid after T.
- The divider detects the change at T+1 and writes `quotient` at T+35.
- `avg_valid` is high in the cycle after edge T+`SETTLE`.
- Minimum window spacing without overrun: `SETTLE` cycles.
- `busy` rises after T and falls after T+`SETTLE`, unless the next window launches on that same edge.

## Configuration
- `AVG_ROUND_EN` defined: round to nearest, ties away from zero.
  - The launched dividend is sum + (`len`>>1) when sum≥0, and sum − (`len`>>1) when sum<0.
- `AVG_ROUND_EN` undefined: the dividend is the raw sum, so the result truncates toward zero.

## Test plan
Bench instantiates this block connected to the divider, with `SETTLE`=40.
- `win_len`=4, samples 10, 20, 30, 40 on consecutive cycles → `dividend`=100, `divisor`=4; one `avg_valid` pulse 40 cycles after the last sample; `avg_out`=25.
- `win_len`=2, samples −7, −8 → without `AVG_ROUND_EN`: `dividend`=−15, `avg_out`=−7. With it: `dividend`=−16, `avg_out`=−8.
- `win_len`=0, sample −5, then idle for 50 cycles → treated as length 1: `divisor`=1, `avg_out`=−5, `overrun`=0.
- `win_len`=1, samples 3 then 9 on consecutive cycles → the 9-window is dropped; `overrun`=1; `avg_out`=3. Then pulse `ovr_clr` → `overrun`=0.
- `win_len`=65535, every sample 32767 → `dividend`=2147385345, `avg_out`=32767. Repeat with every sample −32768 → `avg_out`=−32768.
- `win_len`=2, samples 100, 200, then `rst` asserted 10 cycles later → all outputs return to reset values immediately; no `avg_valid` pulse occurs; a subsequent window averages correctly.
